// File: rtl/vec_axis_packer.sv
// Packs a stream of 16-bit vector elements into 64-bit AXI-Stream beats (four lanes) behind a small FIFO.
// Optional PACKER_TUSER_SOF_EN: drive io_out_tuser high on the first beat of each vector.
module vec_axis_packer #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] io_in_data,
  input  logic        io_in_valid,
  input  logic        io_in_last,
  output logic        io_in_ready,
  output logic [63:0] io_out_tdata,
  output logic        io_out_tvalid,
  input  logic        io_out_tready,
  output logic        io_out_tlast,
  output logic [7:0]  io_out_tkeep,
  output logic        io_out_tuser,
  output logic [15:0] io_vec_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]       r_lane;
  logic [63:0]      r_acc;
  logic [7:0]       r_keep;
  logic [63:0]      r_mem_data [FIFO_DEPTH];
  logic [7:0]       r_mem_keep [FIFO_DEPTH];
  logic             r_mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_vec_count;

  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_valid;
  logic [63:0] w_beat_data;
  logic [7:0]  w_beat_keep;

  // Ready depends only on registered occupancy, so a pop never reopens a full FIFO in the same cycle.
  assign io_in_ready = (r_count < DEPTH_C);
  assign w_valid     = (r_count != '0);
  assign w_accept    = io_in_valid & io_in_ready;
  assign w_push      = w_accept & ((r_lane == 2'd3) | io_in_last);
  assign w_pop       = w_valid & io_out_tready;

  // The current element drops into the lane the counter points at; higher lanes are still zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_beat_data[16*gi +: 16] = (r_lane == 2'(gi)) ? io_in_data : r_acc[16*gi +: 16];
    assign w_beat_keep[2*gi +: 2]   = (r_lane == 2'(gi)) ? 2'b11      : r_keep[2*gi +: 2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lane <= 2'd0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (w_push) begin
      r_lane <= 2'd0;
      r_acc  <= '0;
      r_keep <= '0;
    end else if (w_accept) begin
      r_lane <= r_lane + 2'd1;
      r_acc  <= w_beat_data;
      r_keep <= w_beat_keep;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_beat_data;
      r_mem_keep[r_wr_ptr] <= w_beat_keep;
      r_mem_last[r_wr_ptr] <= io_in_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_vec_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && io_in_last) begin
        r_vec_count <= r_vec_count + 16'd1;
      end
    end
  end

  // Empty FIFO presents an all-zero beat rather than stale RAM contents.
  assign io_out_tvalid = w_valid;
  assign io_out_tdata  = w_valid ? r_mem_data[r_rd_ptr] : '0;
  assign io_out_tkeep  = w_valid ? r_mem_keep[r_rd_ptr] : '0;
  assign io_out_tlast  = w_valid ? r_mem_last[r_rd_ptr] : 1'b0;
  assign io_vec_count  = r_vec_count;

`ifdef PACKER_TUSER_SOF_EN
  logic r_sof;
  logic r_mem_sof [FIFO_DEPTH];

  // Next pushed beat starts a vector if it follows reset or a tlast beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sof <= 1'b1;
    end else if (w_push) begin
      r_sof <= io_in_last;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_sof[r_wr_ptr] <= r_sof;
    end
  end

  assign io_out_tuser = w_valid ? r_mem_sof[r_rd_ptr] : 1'b0;
`else
  assign io_out_tuser = 1'b0;
`endif

endmodule

// File: doc/vec_axis_packer.md
VEC_AXIS_PACKER -- requirements
Module: vec_axis_packer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of 64-bit output beats buffered; legal values are 2 to 16.
REQ-002 Port: clock  input  1  single clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: io_in_data  input  16  one signed vector element.
REQ-005 Port: io_in_valid  input  1  element present.
REQ-006 Port: io_in_last  input  1  element is the final element of its vector.
REQ-007 Port: io_in_ready  output  1  packer accepts an element this cycle.
REQ-008 Port: io_out_tdata  output  64  four 16-bit lanes.
REQ-009 Port: io_out_tvalid  output  1  beat valid.
REQ-010 Port: io_out_tready  input  1  downstream accepts the beat.
REQ-011 Port: io_out_tlast  output  1  beat holds the final element of a vector.
REQ-012 Port: io_out_tkeep  output  8  byte enables, two bits per lane.
REQ-013 Port: io_out_tuser  output  1  start-of-vector marker (see REQ-031).
REQ-014 Port: io_vec_count  output  16  count of vectors whose last beat has been pushed into the FIFO.

Function
REQ-015 An element is accepted when io_in_valid and io_in_ready are both high in the same cycle.
REQ-016 Element k of a beat, k=0..3, occupies io_out_tdata[16k+15:16k]; lane 0 holds the earliest element.
REQ-017 A lane counter tracks fill state with values 0..3: 0 is EMPTY, 1..3 is FILL. The counter advances on each accepted element.
REQ-018 The assembled beat is pushed into the FIFO in the same cycle as the accepted element that fills lane 3, or the accepted element with io_in_last=1, whichever occurs first. The lane counter then returns to 0.
REQ-019 In a pushed beat, unfilled lanes carry data 0 and tkeep bits 00; filled lanes carry tkeep bits 11.
REQ-020 tlast=1 on a pushed beat exactly when that beat contains the io_in_last element.
REQ-021 A single-element vector (io_in_last on lane 0) produces one beat with tkeep=8'h03 and tlast=1.
REQ-022 io_in_ready = (FIFO occupancy < FIFO_DEPTH), computed from registered occupancy only. There is no combinational path from io_out_tready to io_in_ready, so a simultaneous pop does not reopen a full FIFO in the same cycle.
REQ-023 While the FIFO is full, elements that do not complete a beat are also refused; io_in_ready is a single flag.
REQ-024 io_out_tvalid = (FIFO occupancy > 0). The head beat appears one cycle after its push, so latency from the completing element to tvalid is 1 cycle.
REQ-025 A beat is popped when io_out_tvalid and io_out_tready are both high. Push and pop in the same cycle leave occupancy unchanged.
REQ-026 While io_out_tvalid=1 and io_out_tready=0, io_out_tdata, tkeep, tlast and tuser shall hold stable.
REQ-027 The FIFO read and write pointers wrap modulo FIFO_DEPTH; beat order is preserved.
REQ-028 io_vec_count increments by 1 on each push with tlast=1 and wraps from 16'hFFFF to 0.

Reset
REQ-029 On reset the following clear in the same cycle:
  - lane counter to 0; partial beat discarded;
  - FIFO emptied; io_out_tvalid=0, io_out_tdata=0, io_out_tkeep=0, io_out_tlast=0, io_out_tuser=0;
  - io_vec_count=0; io_in_ready=1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-vector or mid-handshake drops all buffered and partial data; no beat is emitted for the interrupted vector.

Configuration
REQ-031 Macro PACKER_TUSER_SOF_EN:
  - defined: io_out_tuser=1 on the first beat of each vector, i.e. the first beat after reset or after a tlast beat; 0 otherwise. A single-beat vector has tuser=1 and tlast=1.
  - undefined: io_out_tuser is tied to 0 and no start-of-vector flag is stored in the FIFO.

Verification
REQ-032 Push elements 1,2,3,4 with last on 4 and tready=1 -> one beat 64'h0004_0003_0002_0001, tkeep=FF, tlast=1, tuser=1 (macro defined), io_vec_count=1.
REQ-033 Push 5 elements 0x10..0x14 with last on 0x14 -> beat1 64'h0013_0012_0011_0010 tkeep=FF tlast=0, then beat2 64'h0000_0000_0000_0014 tkeep=03 tlast=1.
REQ-034 FIFO_DEPTH=2, tready=0, stream 12 elements -> io_in_ready falls after the 8th accepted element; tdata holds stable; raising tready pops 2 beats in order, after which the remaining 4 elements are accepted.
REQ-035 FIFO full with push and pop in the same cycle -> io_in_ready stays 0 that cycle; occupancy is unchanged; no beat is lost or duplicated.
REQ-036 Accept 2 elements, assert reset for 1 cycle, then send vector 7,8 with last -> single beat 64'h0000_0000_0008_0007 tkeep=0F, io_vec_count=1.
REQ-037 Drive 65536 single-element vectors -> io_vec_count wraps to 0; macro undefined -> tuser stays 0 throughout.
